rv_exec_issue: RTL and testbench

RV_EXEC_ISSUE -- requirements
Module: rv_exec_issue

---
 rtl/rv_exec_issue_pkg.sv | 34 +++
 rtl/rv_exec_issue_if.sv | 50 +++++
 rtl/rv_exec_issue_add.sv | 16 +
 rtl/rv_exec_issue.sv | 168 ++++++++++++++++
 tb/tb_rv_exec_issue.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_exec_issue_pkg.sv
// Shared types for the execute issue stage.
// Control bundle carried from decode through the issue buffer.
package rv_exec_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU, RES_MEM, RES_PC4, RES_CSR
  } res_src_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    alu_ctrl_t   alu_ctrl;
    res_src_t    res_src;
    logic        reg_write;
    logic        op1_src;
    logic        op2_src;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic        mret;
    logic        store;
    logic        to_trap;
  } issue_ctrl_t;

endpackage

// File: rtl/rv_exec_issue_if.sv
// Upstream/downstream handshake bundle of the issue stage.
// slave = the stage itself, master = whoever drives it.
interface rv_exec_issue_if
  import rv_exec_issue_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 32
) ();

  logic                        i_valid;
  logic                        o_ready;
  issue_ctrl_t                 i_ctrl;
  logic [IADDR_SPACE_BITS-1:1] i_pc;
  logic [IADDR_SPACE_BITS-1:1] i_pc_next;
  logic [IADDR_SPACE_BITS-1:1] i_ret_addr;
  logic [31:0]                 i_reg1_data;
  logic [31:0]                 i_reg2_data;

  logic                        o_valid;
  logic                        i_ready;
  issue_ctrl_t                 o_ctrl;
  logic [31:0]                 o_op1;
  logic [31:0]                 o_op2;
  logic [31:0]                 o_reg_data1;
  logic [31:0]                 o_reg_data2;
  logic [IADDR_SPACE_BITS-1:1] o_pc;
  logic [IADDR_SPACE_BITS-1:1] o_pc_next;
  logic [IADDR_SPACE_BITS-1:1] o_pc_target;
  logic                        o_inst_jal_jalr;

  modport slave (
    input  i_valid, i_ctrl, i_pc, i_pc_next,
    input  i_ret_addr, i_reg1_data, i_reg2_data,
    input  i_ready,
    output o_ready, o_valid, o_ctrl,
    output o_op1, o_op2, o_reg_data1, o_reg_data2,
    output o_pc, o_pc_next, o_pc_target,
    output o_inst_jal_jalr
  );

  modport master (
    output i_valid, i_ctrl, i_pc, i_pc_next,
    output i_ret_addr, i_reg1_data, i_reg2_data,
    output i_ready,
    input  o_ready, o_valid, o_ctrl,
    input  o_op1, o_op2, o_reg_data1, o_reg_data2,
    input  o_pc, o_pc_next, o_pc_target,
    input  o_inst_jal_jalr
  );

endinterface

// File: rtl/rv_exec_issue_add.sv
// Plain ripple adder with carry in/out.
// Shared by the PC target path.
module rv_exec_issue_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b}
                 + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/rv_exec_issue.sv
// Execute issue stage: two-entry head/skid buffer with
// operand bypass, operand muxing and PC target generation.
module rv_exec_issue
  import rv_exec_issue_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int FWD_PORTS        = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_flush,
  input  logic [FWD_PORTS-1:0]    i_fwd_valid,
  input  logic [5*FWD_PORTS-1:0]  i_fwd_rd,
  input  logic [32*FWD_PORTS-1:0] i_fwd_data,
  rv_exec_issue_if.slave          bus
);

  localparam int AW = IADDR_SPACE_BITS;

  // Lowest-numbered matching port wins; x0 is never replaced.
  function automatic logic [31:0] byp(
    input logic [4:0]              rs,
    input logic [31:0]             d,
    input logic [FWD_PORTS-1:0]    fv,
    input logic [5*FWD_PORTS-1:0]  frd,
    input logic [32*FWD_PORTS-1:0] fd
  );
    logic [31:0] r;
    r = d;
    for (int k = FWD_PORTS-1; k >= 0; k--) begin
      if (fv[k] && frd[5*k +: 5] == rs && rs != 5'd0)
        r = fd[32*k +: 32];
    end
    return r;
  endfunction

  logic           head_valid, skid_valid;
  issue_ctrl_t    head_ctrl, skid_ctrl;
  logic [AW-1:1]  head_pc, head_pc_next;
  logic [AW-1:1]  skid_pc, skid_pc_next;
  logic [31:0]    head_r1, head_r2;
  logic [31:0]    skid_r1, skid_r2;

  logic [31:0]    h_r1, h_r2, s_r1, s_r2, n_r1, n_r2;
  logic           accept, consume;

  assign accept  = bus.i_valid & ~skid_valid;
  assign consume = head_valid & bus.i_ready;

  assign h_r1 = byp(head_ctrl.rs1, head_r1,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign h_r2 = byp(head_ctrl.rs2, head_r2,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign s_r1 = byp(skid_ctrl.rs1, skid_r1,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign s_r2 = byp(skid_ctrl.rs2, skid_r2,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign n_r1 = byp(bus.i_ctrl.rs1, bus.i_reg1_data,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);
  assign n_r2 = byp(bus.i_ctrl.rs2, bus.i_reg2_data,
                    i_fwd_valid, i_fwd_rd, i_fwd_data);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      head_ctrl    <= '0;
      skid_ctrl    <= '0;
      head_pc      <= '0;
      head_pc_next <= '0;
      skid_pc      <= '0;
      skid_pc_next <= '0;
      head_r1      <= '0;
      head_r2      <= '0;
      skid_r1      <= '0;
      skid_r2      <= '0;
    end else begin
      head_r1 <= h_r1;
      head_r2 <= h_r2;
      skid_r1 <= s_r1;
      skid_r2 <= s_r2;
      if (i_flush) begin
        head_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!head_valid || consume) begin
        if (skid_valid) begin
          head_ctrl    <= skid_ctrl;
          head_pc      <= skid_pc;
          head_pc_next <= skid_pc_next;
          head_r1      <= s_r1;
          head_r2      <= s_r2;
          head_valid   <= 1'b1;
          skid_valid   <= accept;
          if (accept) begin
            skid_ctrl    <= bus.i_ctrl;
            skid_pc      <= bus.i_pc;
            skid_pc_next <= bus.i_pc_next;
            skid_r1      <= n_r1;
            skid_r2      <= n_r2;
          end
        end else begin
          head_valid <= accept;
          if (accept) begin
            head_ctrl    <= bus.i_ctrl;
            head_pc      <= bus.i_pc;
            head_pc_next <= bus.i_pc_next;
            head_r1      <= n_r1;
            head_r2      <= n_r2;
          end
        end
      end else if (accept) begin
        skid_valid   <= 1'b1;
        skid_ctrl    <= bus.i_ctrl;
        skid_pc      <= bus.i_pc;
        skid_pc_next <= bus.i_pc_next;
        skid_r1      <= n_r1;
        skid_r2      <= n_r2;
      end
    end
  end

  logic [AW-1:1] tgt_base, tgt_off;
  logic          tgt_co_unused;

  assign tgt_base = head_ctrl.mret ? bus.i_ret_addr
                  : head_ctrl.jalr ? h_r1[AW-1:1]
                  : head_pc;
  assign tgt_off  = head_ctrl.mret ? '0
                  : head_ctrl.imm[AW-1:1];

  rv_exec_issue_add #(
    .WIDTH(AW-1)
  ) u_tgt_add (
    .a  (tgt_base),
    .b  (tgt_off),
    .ci (1'b0),
    .s  (bus.o_pc_target),
    .co (tgt_co_unused)
  );

  assign bus.o_valid     = head_valid;
  assign bus.o_ready     = ~skid_valid;
  assign bus.o_reg_data1 = h_r1;
  assign bus.o_reg_data2 = h_r2;
  assign bus.o_pc        = head_pc;
  assign bus.o_pc_next   = head_pc_next;
  assign bus.o_op1 = head_ctrl.op1_src
                   ? 32'({head_pc, 1'b0}) : h_r1;
  assign bus.o_op2 = head_ctrl.op2_src
                   ? head_ctrl.imm : h_r2;
  assign bus.o_inst_jal_jalr = head_valid
    & (head_ctrl.jal | head_ctrl.jalr | head_ctrl.mret);

  // Side-effect bits must never leak from an empty head.
  always_comb begin
    bus.o_ctrl = head_ctrl;
    if (!head_valid) begin
      bus.o_ctrl.reg_write = 1'b0;
      bus.o_ctrl.store     = 1'b0;
      bus.o_ctrl.jal       = 1'b0;
      bus.o_ctrl.jalr      = 1'b0;
      bus.o_ctrl.branch    = 1'b0;
      bus.o_ctrl.mret      = 1'b0;
      bus.o_ctrl.to_trap   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_exec_issue.sv
// Scoreboard bench for rv_exec_issue: directed vectors,
// expected results queued on accept and popped on consume.
module tb_rv_exec_issue;
  import rv_exec_issue_pkg::*;

  localparam int IAB = 32;
  localparam int FP  = 2;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] tgt;
  } exp_t;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            flush = 1'b0;
  logic [FP-1:0]   fv    = '0;
  logic [5*FP-1:0] frd   = '0;
  logic [32*FP-1:0] fdata = '0;

  rv_exec_issue_if #(.IADDR_SPACE_BITS(IAB)) bus ();

  rv_exec_issue #(
    .IADDR_SPACE_BITS(IAB),
    .FWD_PORTS(FP)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_flush     (flush),
    .i_fwd_valid (fv),
    .i_fwd_rd    (frd),
    .i_fwd_data  (fdata),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t exp_in;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic exp_t mke(input logic [4:0] tag,
                               input logic [31:0] op1, op2,
                               input logic [31:0] r1, r2, tgt);
    exp_t e;
    e.tag = tag; e.op1 = op1; e.op2 = op2;
    e.r1 = r1; e.r2 = r2; e.tgt = tgt;
    return e;
  endfunction

  function automatic issue_ctrl_t mk(input logic [4:0] rs1, rs2, rd,
                                     input logic [31:0] imm,
                                     input logic o1, o2);
    issue_ctrl_t c;
    c = '0;
    c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.imm = imm;
    c.op1_src = o1; c.op2_src = o2;
    c.alu_ctrl = ALU_ADD;
    c.res_src = RES_ALU;
    c.reg_write = 1'b1;
    return c;
  endfunction

  task automatic put(input issue_ctrl_t c,
                     input logic [31:0] pc, r1, r2,
                     input exp_t e);
    bus.i_ctrl      = c;
    bus.i_pc        = pc[31:1];
    bus.i_pc_next   = pc[31:1] + 31'd2;
    bus.i_reg1_data = r1;
    bus.i_reg2_data = r2;
    exp_in          = e;
    bus.i_valid     = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consume pops and compares, accept pushes.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.o_valid && bus.i_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got tag %0d want none",
                   bus.o_ctrl.rd);
        end else begin
          e = sb.pop_front();
          chk("tag", 32'(bus.o_ctrl.rd), 32'(e.tag));
          chk("op1", bus.o_op1, e.op1);
          chk("op2", bus.o_op2, e.op2);
          chk("reg1", bus.o_reg_data1, e.r1);
          chk("reg2", bus.o_reg_data2, e.r2);
          chk("target", {bus.o_pc_target, 1'b0}, e.tgt);
        end
      end
      if (flush)
        sb.delete();
      else if (bus.i_valid && bus.o_ready)
        sb.push_back(exp_in);
    end
  end

  issue_ctrl_t c;

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_ctrl      = '0;
    bus.i_pc        = '0;
    bus.i_pc_next   = '0;
    bus.i_ret_addr  = 31'h100;
    bus.i_reg1_data = '0;
    bus.i_reg2_data = '0;
    exp_in = mke(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_op1", bus.o_op1, 32'd0);
    chk("rst_target", {bus.o_pc_target, 1'b0}, 32'd0);
    chk("rst_ctrl", 32'(bus.o_ctrl.reg_write), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // add x3,x1,x2
    bus.i_ready = 1'b1;
    put(mk(1, 2, 3, 0, 0, 0), 32'h100, 5, 7,
        mke(3, 5, 7, 5, 7, 32'h100));
    tick();
    chk("lat_valid", 32'(bus.o_valid), 32'd1);
    chk("lat_ready", 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b0;
    tick();

    // back-pressure with three back-to-back inputs
    bus.i_ready = 1'b0;
    put(mk(1, 2, 5, 0, 0, 0), 32'h180, 32'h11, 32'h22,
        mke(5, 32'h11, 32'h22, 32'h11, 32'h22, 32'h180));
    tick();
    put(mk(1, 2, 6, 32'h30, 1, 1), 32'h200, 32'h33, 32'h44,
        mke(6, 32'h200, 32'h30, 32'h33, 32'h44, 32'h230));
    tick();
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    chk("full_valid", 32'(bus.o_valid), 32'd1);
    c = mk(1, 2, 7, 8, 0, 0);
    c.branch = 1'b1;
    put(c, 32'h300, 32'h55, 32'h66,
        mke(7, 32'h55, 32'h66, 32'h55, 32'h66, 32'h308));
    tick();
    chk("stall_ready", 32'(bus.o_ready), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();

    // bypass into a stalled head, then port priority
    bus.i_ready = 1'b0;
    put(mk(4, 0, 8, 0, 0, 0), 32'h400, 1, 2,
        mke(8, 32'hB0, 2, 32'hB0, 2, 32'h400));
    tick();
    bus.i_valid = 1'b0;
    fv = 2'b10;
    frd = {5'd4, 5'd0};
    fdata = {32'hAA, 32'h0};
    #1;
    chk("fwd_comb", bus.o_reg_data1, 32'hAA);
    tick();
    fv = '0;
    #1;
    chk("fwd_held", bus.o_reg_data1, 32'hAA);
    tick();
    fv = 2'b11;
    frd = {5'd4, 5'd4};
    fdata = {32'hC0, 32'hB0};
    #1;
    chk("fwd_prio", bus.o_reg_data1, 32'hB0);
    chk("fwd_x0", bus.o_reg_data2, 32'h2);
    tick();
    fv = '0;
    bus.i_ready = 1'b1;
    tick();

    // PC targets: jalr with bypassed base, mret, wrap
    c = mk(6, 8, 1, 32'hFFC, 0, 1);
    c.jalr = 1'b1;
    put(c, 32'h500, 5, 9,
        mke(1, 32'h1000, 32'hFFC, 32'h1000, 9, 32'h1FFC));
    fv = 2'b01;
    frd = {5'd0, 5'd6};
    fdata = {32'h0, 32'h1000};
    tick();
    fv = '0;
    chk("jalr_flag", 32'(bus.o_inst_jal_jalr), 32'd1);
    c = mk(2, 3, 0, 32'h44, 0, 0);
    c.reg_write = 1'b0;
    c.mret = 1'b1;
    put(c, 32'h700, 3, 4, mke(0, 3, 4, 3, 4, 32'h200));
    tick();
    chk("mret_flag", 32'(bus.o_inst_jal_jalr), 32'd1);
    c = mk(9, 10, 2, 4, 1, 0);
    c.branch = 1'b1;
    put(c, 32'hFFFFFFFE, 32'h12, 32'h34,
        mke(2, 32'hFFFFFFFE, 32'h34, 32'h12, 32'h34, 32'h2));
    tick();
    bus.i_valid = 1'b0;
    tick();

    // flush beats a simultaneous accept
    bus.i_ready = 1'b0;
    put(mk(1, 2, 11, 0, 0, 0), 32'h800, 1, 2,
        mke(11, 1, 2, 1, 2, 32'h800));
    tick();
    put(mk(1, 2, 12, 0, 0, 0), 32'h810, 1, 2,
        mke(12, 1, 2, 1, 2, 32'h810));
    tick();
    chk("pre_flush_ready", 32'(bus.o_ready), 32'd0);
    put(mk(1, 2, 13, 0, 0, 0), 32'h820, 1, 2,
        mke(13, 1, 2, 1, 2, 32'h820));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("flush_valid", 32'(bus.o_valid), 32'd0);
    chk("flush_ready", 32'(bus.o_ready), 32'd1);
    chk("flush_rw", 32'(bus.o_ctrl.reg_write), 32'd0);
    bus.i_ready = 1'b1;
    tick();
    tick();

    // x0 never bypassed; async reset with both entries held
    bus.i_ready = 1'b0;
    put(mk(0, 5, 14, 0, 0, 0), 32'h900, 32'h77, 32'h88,
        mke(14, 32'h77, 32'h88, 32'h77, 32'h88, 32'h900));
    fv = 2'b01;
    frd = {5'd0, 5'd0};
    fdata = {32'h0, 32'hDEAD};
    tick();
    chk("x0_comb", bus.o_reg_data1, 32'h77);
    put(mk(1, 2, 15, 0, 0, 0), 32'h910, 1, 2,
        mke(15, 1, 2, 1, 2, 32'h910));
    tick();
    fv = '0;
    bus.i_valid = 1'b0;
    chk("x0_held", bus.o_reg_data1, 32'h77);
    chk("two_held_ready", 32'(bus.o_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_ready", 32'(bus.o_ready), 32'd1);
    chk("arst_op1", bus.o_op1, 32'd0);
    chk("arst_rw", 32'(bus.o_ctrl.reg_write), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;

    // stage works again after reset
    bus.i_ready = 1'b1;
    put(mk(1, 2, 16, 0, 0, 0), 32'hA00, 32'hA, 32'hB,
        mke(16, 32'hA, 32'hB, 32'hA, 32'hB, 32'hA00));
    tick();
    bus.i_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
